// File: rtl/sha256_round_ctrl_pkg.sv
// Purpose : shared SHA-256 constants and the round-controller state encoding.
// Latency : n/a (constants, types and a pure lookup function only).
// Backpr. : n/a.
// Contents: ctrl_state_e (IDLE/LOAD/ROUNDS/DONE), SHA256_ROUNDS, K[0..63] table,
//           IV H0..H7, and sha256_k() for K[t] lookup by round index.
package sha256_pkg;

  localparam int SHA256_ROUNDS = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    ROUNDS = 2'd2,
    DONE   = 2'd3
  } ctrl_state_e;

  localparam logic [31:0] SHA256_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] SHA256_IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // Round constant for round t, indexed directly by round_idx.
  function automatic logic [31:0] sha256_k(input logic [5:0] t);
    return SHA256_K[t];
  endfunction

endpackage

// File: rtl/sha256_round_ctrl_if.sv
// Purpose : command/strobe bundle between the register interface and the round controller.
// Latency : n/a (wires only).
// Backpr. : ready gates init/next; commands seen while ready=0 are dropped, not queued.
// Modports: master = requester side (drives init/next, observes strobes);
//           slave  = controller side (takes init/next, drives ready/strobes/round_idx).
//           blk_count exists only when SHA256_CTRL_BLKCNT_EN is defined.
interface sha256_round_ctrl_if #(
  parameter int ROUND_W = 6
`ifdef SHA256_CTRL_BLKCNT_EN
  , parameter int BLKCNT_W = 32
`endif
);
  logic               init;
  logic               next;
  logic               ready;
  logic               ms_load;
  logic               iv_load;
  logic               wv_load;
  logic               round_en;
  logic [ROUND_W-1:0] round_idx;
  logic               digest_update;
  logic               digest_valid;
`ifdef SHA256_CTRL_BLKCNT_EN
  logic [BLKCNT_W-1:0] blk_count;
`endif

  modport master (
`ifdef SHA256_CTRL_BLKCNT_EN
    input  blk_count,
`endif
    output init, next,
    input  ready, ms_load, iv_load, wv_load, round_en, round_idx,
           digest_update, digest_valid
  );

  modport slave (
`ifdef SHA256_CTRL_BLKCNT_EN
    output blk_count,
`endif
    input  init, next,
    output ready, ms_load, iv_load, wv_load, round_en, round_idx,
           digest_update, digest_valid
  );
endinterface

// File: rtl/sha256_round_ctrl_counter.sv
// Purpose : loadable round-index up-counter with terminal-count flag at NUM_ROUNDS-1.
// Latency : cnt updates one edge after load/en; tc is decoded from the count register.
// Backpr. : none; counts only while en=1, load has priority over en.
// Ports   : clk, reset_n (async active-low), load/load_val, en -> cnt, tc.
module sha256_round_counter #(
  parameter  int NUM_ROUNDS = 64,
  localparam int W          = $clog2(NUM_ROUNDS)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  // Terminal count is the last round, so the FSM leaves ROUNDS before any wrap.
  assign tc  = (cnt_q == W'(NUM_ROUNDS - 1));

endmodule

// File: rtl/sha256_round_ctrl.sv
// Purpose : sequences one SHA-256 block: schedule load, NUM_ROUNDS round enables, digest accumulate.
// Latency : ready low for NUM_ROUNDS+2 cycles after accept (LOAD, ROUNDS x N, DONE); 66 at default.
// Backpr. : init/next accepted only while ready=1 (IDLE); otherwise silently ignored.
// Ports   : clk, reset_n (async active-low), ctrl (sha256_round_ctrl_if.slave).
//           Optional block counter on ctrl.blk_count with SHA256_CTRL_BLKCNT_EN.
//           All outputs are flops or state decodes; no input-to-output path.
module sha256_round_ctrl
  import sha256_pkg::*;
#(
  parameter int NUM_ROUNDS = SHA256_ROUNDS
`ifdef SHA256_CTRL_BLKCNT_EN
  , parameter int BLKCNT_W = 32
`endif
) (
  input  logic                clk,
  input  logic                reset_n,
  sha256_round_ctrl_if.slave  ctrl
);

  localparam int ROUND_W = $clog2(NUM_ROUNDS);

  ctrl_state_e        state_q;
  ctrl_state_e        state_d;
  // Remembers which command started the block so LOAD can pick iv_load vs wv_load.
  logic               is_init_q;
  logic               is_init_d;
  logic               digest_valid_q;
  logic               digest_valid_d;

  logic               cnt_load;
  logic               cnt_en;
  logic [ROUND_W-1:0] cnt;
  logic               cnt_tc;

  sha256_round_counter #(
    .NUM_ROUNDS (NUM_ROUNDS)
  ) u_round_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val ('0),
    .en       (cnt_en),
    .cnt      (cnt),
    .tc       (cnt_tc)
  );

  always_comb begin
    state_d        = state_q;
    is_init_d      = is_init_q;
    digest_valid_d = digest_valid_q;
    cnt_load       = 1'b0;
    cnt_en         = 1'b0;
    case (state_q)
      IDLE: begin
        if (ctrl.init || ctrl.next) begin
          state_d        = LOAD;
          is_init_d      = ctrl.init;  // init wins when both are high
          digest_valid_d = 1'b0;
        end
      end
      LOAD: begin
        state_d  = ROUNDS;
        cnt_load = 1'b1;                // round 0 is presented on ROUNDS entry
      end
      ROUNDS: begin
        cnt_en = 1'b1;
        if (cnt_tc) begin
          state_d  = DONE;
          cnt_load = 1'b1;              // park round_idx at 0 for DONE/IDLE
        end
      end
      DONE: begin
        state_d        = IDLE;
        digest_valid_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      is_init_q      <= 1'b0;
      digest_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      is_init_q      <= is_init_d;
      digest_valid_q <= digest_valid_d;
    end
  end

  assign ctrl.ready         = (state_q == IDLE);
  assign ctrl.ms_load       = (state_q == LOAD);
  assign ctrl.iv_load       = (state_q == LOAD) &&  is_init_q;
  assign ctrl.wv_load       = (state_q == LOAD) && !is_init_q;
  assign ctrl.round_en      = (state_q == ROUNDS);
  assign ctrl.round_idx     = cnt;
  assign ctrl.digest_update = (state_q == DONE);
  assign ctrl.digest_valid  = digest_valid_q;

`ifdef SHA256_CTRL_BLKCNT_EN
  logic [BLKCNT_W-1:0] blk_count_q;
  logic [BLKCNT_W-1:0] blk_count_d;

  // Counts completed blocks; only reset_n clears it, init leaves it alone.
  always_comb begin
    blk_count_d = blk_count_q;
    if (state_q == DONE) begin
      blk_count_d = blk_count_q + BLKCNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blk_count_q <= '0;
    end else begin
      blk_count_q <= blk_count_d;
    end
  end

  assign ctrl.blk_count = blk_count_q;
`endif

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Purpose : self-checking bench for sha256_round_ctrl (default NUM_ROUNDS=64).
// Latency : n/a.
// Backpr. : n/a.
module tb_sha256_round_ctrl;

  typedef struct packed {
    logic       ready;
    logic       ms;
    logic       iv;
    logic       wv;
    logic       ren;
    logic [5:0] idx;
    logic       du;
    logic       dv;
  } obs_t;

  typedef struct packed {
    logic iv;
    logic wv;
  } ld_t;

  typedef struct {
    logic  init;
    logic  nxt;
    logic  exp_iv;
    logic  exp_wv;
    string name;
  } vec_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   total   = 0;
  int   bad     = 0;
  int   cyc     = 0;
  ld_t  ld_q[$];
  int   du_cyc[$];

  sha256_round_ctrl_if #(.ROUND_W(6)) bus();

  sha256_round_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ctrl    (bus)
  );

  always #5 clk = ~clk;

  function automatic obs_t sample_now();
    obs_t o;
    o.ready = bus.ready;
    o.ms    = bus.ms_load;
    o.iv    = bus.iv_load;
    o.wv    = bus.wv_load;
    o.ren   = bus.round_en;
    o.idx   = bus.round_idx;
    o.du    = bus.digest_update;
    o.dv    = bus.digest_valid;
    return o;
  endfunction

  // Expected outputs k cycles after the accepting edge (k=1 is the LOAD cycle).
  function automatic obs_t exp_at(int k, logic iv, logic wv);
    obs_t e;
    e = '0;
    if (k == 1) begin
      e.ms = 1'b1;
      e.iv = iv;
      e.wv = wv;
    end else if (k >= 2 && k <= 65) begin
      e.ren = 1'b1;
      e.idx = 6'(k - 2);
    end else if (k == 66) begin
      e.du = 1'b1;
    end else begin
      e.ready = 1'b1;
      e.dv    = 1'b1;
    end
    return e;
  endfunction

  function automatic obs_t idle_vals(logic dv);
    obs_t e;
    e       = '0;
    e.ready = 1'b1;
    e.dv    = dv;
    return e;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("rdy=%b ms=%b iv=%b wv=%b ren=%b idx=%0d du=%b dv=%b",
                     o.ready, o.ms, o.iv, o.wv, o.ren, o.idx, o.du, o.dv);
  endfunction

  task automatic check_obs(string nm, obs_t got, obs_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got {%s} want {%s}", nm, fmt(got), fmt(exp));
    end
  endtask

  task automatic check_int(string nm, longint got, longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, exp);
    end
  endtask

  // Scoreboard side: every schedule load the DUT issues must match a queued command.
  task automatic observe();
    ld_t e;
    if (bus.ms_load === 1'b1) begin
      if (ld_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected_load: got ms_load=1 want no load (queue empty)");
      end else begin
        e = ld_q.pop_front();
        check_int("sb_load_iv", longint'(bus.iv_load), longint'(e.iv));
        check_int("sb_load_wv", longint'(bus.wv_load), longint'(e.wv));
      end
    end
    if (bus.digest_update === 1'b1) du_cyc.push_back(cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    observe();
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (bus.ready !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    check_int("wait_ready", longint'(bus.ready === 1'b1), 1);
  endtask

  task automatic start(logic i, logic n, ld_t e);
    bus.init = i;
    bus.next = n;
    ld_q.push_back(e);
    step();
    bus.init = 1'b0;
    bus.next = 1'b0;
  endtask

  // Checks every cycle of a block; optionally pulses next at cycle poke_k,
  // and returns early after checking cycle stop_k (0 = run to the idle cycle).
  task automatic run_block(string nm, logic iv, logic wv, int poke_k, int stop_k);
    for (int k = 1; k <= 67; k++) begin
      check_obs($sformatf("%s_k%0d", nm, k), sample_now(), exp_at(k, iv, wv));
      if (k == stop_k) return;
      if (k == poke_k) bus.next = 1'b1;
      if (k < 67) begin
        step();
        if (k == poke_k) bus.next = 1'b0;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    int   n_du;
    vecs[0] = '{init: 1'b1, nxt: 1'b0, exp_iv: 1'b1, exp_wv: 1'b0, name: "init_only"};
    vecs[1] = '{init: 1'b0, nxt: 1'b1, exp_iv: 1'b0, exp_wv: 1'b1, name: "next_only"};
    vecs[2] = '{init: 1'b1, nxt: 1'b1, exp_iv: 1'b1, exp_wv: 1'b0, name: "init_and_next"};
    vecs[3] = '{init: 1'b0, nxt: 1'b1, exp_iv: 1'b0, exp_wv: 1'b1, name: "next_again"};

    bus.init = 1'b0;
    bus.next = 1'b0;
    #2;
    check_obs("reset_state", sample_now(), idle_vals(1'b0));
`ifdef SHA256_CTRL_BLKCNT_EN
    check_int("reset_blk_count", longint'(bus.blk_count), 0);
`endif
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    step();
    check_obs("post_reset_idle", sample_now(), idle_vals(1'b0));

    // Table-driven command patterns, each run as a full checked block.
    for (int i = 0; i < 4; i++) begin
      wait_ready();
      start(vecs[i].init, vecs[i].nxt, '{iv: vecs[i].exp_iv, wv: vecs[i].exp_wv});
      run_block(vecs[i].name, vecs[i].exp_iv, vecs[i].exp_wv, -1, 0);
    end

    // next pulsed at round_idx=10 must be dropped.
    start(1'b1, 1'b0, '{iv: 1'b1, wv: 1'b0});
    run_block("ignored_next", 1'b1, 1'b0, 12, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_obs($sformatf("idle_after_ignored_%0d", i), sample_now(), idle_vals(1'b1));
    end
    check_int("no_extra_load", longint'(ld_q.size()), 0);

    // next held high from the LOAD cycle of an init block: accepted right at ready.
    du_cyc.delete();
    start(1'b1, 1'b0, '{iv: 1'b1, wv: 1'b0});
    bus.next = 1'b1;
    run_block("held_first", 1'b1, 1'b0, -1, 0);
    ld_q.push_back('{iv: 1'b0, wv: 1'b1});
    step();
    run_block("held_second", 1'b0, 1'b1, -1, 0);
    bus.next = 1'b0;
    step();
    check_obs("held_idle", sample_now(), idle_vals(1'b1));
    check_int("held_du_count", longint'(du_cyc.size()), 2);
    if (du_cyc.size() >= 2)
      check_int("held_du_spacing", longint'(du_cyc[1] - du_cyc[0]), 67);

    // Asynchronous reset in the middle of the rounds (round_idx=30).
    n_du = du_cyc.size();
    start(1'b1, 1'b0, '{iv: 1'b1, wv: 1'b0});
    run_block("pre_abort", 1'b1, 1'b0, -1, 32);
    #1;
    reset_n = 1'b0;
    #1;
    check_obs("async_reset", sample_now(), idle_vals(1'b0));
    for (int i = 0; i < 3; i++) begin
      step();
      check_obs($sformatf("in_reset_%0d", i), sample_now(), idle_vals(1'b0));
    end
    reset_n = 1'b1;
    step();
    check_obs("after_abort", sample_now(), idle_vals(1'b0));
    check_int("abort_no_digest_update", longint'(du_cyc.size()), longint'(n_du));

`ifdef SHA256_CTRL_BLKCNT_EN
    check_int("blkcnt_after_abort", longint'(bus.blk_count), 0);
    for (int i = 0; i < 3; i++) begin
      wait_ready();
      start(1'b0, 1'b1, '{iv: 1'b0, wv: 1'b1});
      run_block($sformatf("cnt_blk%0d", i), 1'b0, 1'b1, -1, 0);
      check_int($sformatf("blkcnt_%0d", i), longint'(bus.blk_count), longint'(i + 1));
    end
    reset_n = 1'b0;
    #1;
    check_int("blkcnt_reset", longint'(bus.blk_count), 0);
    step();
    reset_n = 1'b1;
    step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
